clct_busy_scheduler: RTL

Sequences the 5-CFEB best-of-5 CLCT selector through a two-pass search per trigger window. The first pass picks CLCT0. The block then drives the per-CFEB busy flags so the second pass picks CLCT1 from the remaining CFEBs. It finally holds a programmable dead time before re-arming. It sits between the pattern-finder selector (consumes its best key/valid, drives its `bsy0..bsy4`) and the CLCT output register stage.

---
 rtl/clct_busy_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/clct_busy_scheduler.sv
// Two-pass CLCT scheduler: picks CLCT0, busies its CFEBs so the selector finds CLCT1, then holds a dead time.
// Optional build macro CLCT_SPREAD_EN widens each claim to a +/- spread half-strip window.
module clct_busy_scheduler #(
    parameter int MXCFEB  = 5,
    parameter int MXKEYBX = 8,
    parameter int MXDRB   = 4
) (
    input  logic               clock,
    input  logic               global_reset_n,
    input  logic [MXCFEB-1:0]  cfeb_en,
    input  logic [MXDRB-1:0]   drift_delay,
    input  logic [MXDRB-1:0]   dead_time,
    input  logic [2:0]         spread,
    input  logic               best_vpf,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic               best_bsy,
    output logic [MXCFEB-1:0]  bsy,
    output logic [MXKEYBX-1:0] clct0_key,
    output logic [MXKEYBX-1:0] clct1_key,
    output logic               clct0_vld,
    output logic               clct1_vld,
    output logic               clct_done,
    output logic [1:0]         sched_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SECOND = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam logic [MXKEYBX-1:0]        KEY_MAX   = MXKEYBX'(223);
    localparam logic signed [MXKEYBX+1:0] KEY_MAX_S = (MXKEYBX+2)'(223);

    logic [1:0]         state_reg, state_next;
    logic [MXDRB-1:0]   dead_cnt_reg, dead_cnt_next;
    logic               done_reg, done_next;
    logic [MXKEYBX-1:0] clct0_key_reg, clct1_key_reg;
    logic               clct0_vld_reg, clct1_vld_reg;
    logic               latch0, latch1;
    logic               acc;
    logic               claim_win;
    logic [2:0]         lo_cfeb, hi_cfeb;
    logic [MXCFEB-1:0]  busy_vec;

    assign acc       = best_vpf && !best_bsy;
    assign claim_win = acc && ((state_reg == ST_IDLE) || (state_reg == ST_SECOND));

`ifdef CLCT_SPREAD_EN
    logic signed [MXKEYBX+1:0] lo_raw, hi_raw;
    logic [MXKEYBX-1:0]        lo_clip, hi_clip;

    // Two extra bits keep key-spread negative and key+spread above 255 representable.
    assign lo_raw  = $signed({2'b00, best_key}) - $signed({{(MXKEYBX-1){1'b0}}, spread});
    assign hi_raw  = $signed({2'b00, best_key}) + $signed({{(MXKEYBX-1){1'b0}}, spread});
    assign lo_clip = (lo_raw < 0) ? '0 : lo_raw[MXKEYBX-1:0];
    assign hi_clip = (hi_raw > KEY_MAX_S) ? KEY_MAX : hi_raw[MXKEYBX-1:0];
    assign lo_cfeb = lo_clip[MXKEYBX-1 -: 3];
    assign hi_cfeb = hi_clip[MXKEYBX-1 -: 3];

    wire unused_bits = ^{lo_clip[MXKEYBX-4:0], hi_clip[MXKEYBX-4:0]};
`else
    assign lo_cfeb = best_key[MXKEYBX-1 -: 3];
    assign hi_cfeb = best_key[MXKEYBX-1 -: 3];

    wire unused_bits = ^{spread, best_key[MXKEYBX-4:0], KEY_MAX, KEY_MAX_S};
`endif

    // Per-CFEB drift counters run regardless of scheduler state.
    genvar gi;
    generate
        for (gi = 0; gi < MXCFEB; gi++) begin : g_cfeb
            logic [MXDRB-1:0] drift_cnt_reg;
            logic             busy_reg;
            logic             claim;

            assign claim = claim_win && (lo_cfeb <= 3'(gi)) && (3'(gi) <= hi_cfeb);

            always_ff @(posedge clock) begin
                if (!global_reset_n) begin
                    drift_cnt_reg <= '0;
                    busy_reg      <= 1'b0;
                end else if (claim) begin
                    drift_cnt_reg <= drift_delay;
                    busy_reg      <= 1'b1;
                end else begin
                    busy_reg <= (drift_cnt_reg != '0);
                    if (drift_cnt_reg != '0) begin
                        drift_cnt_reg <= drift_cnt_reg - MXDRB'(1);
                    end
                end
            end

            assign busy_vec[gi] = busy_reg;
            assign bsy[gi]      = busy_reg | ~cfeb_en[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        dead_cnt_next = dead_cnt_reg;
        done_next     = 1'b0;
        latch0        = 1'b0;
        latch1        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (acc) begin
                    latch0     = 1'b1;
                    state_next = ST_SECOND;
                end
            end
            ST_SECOND: begin
                latch1        = acc;
                done_next     = 1'b1;
                dead_cnt_next = dead_time;
                state_next    = ST_DEAD;
            end
            ST_DEAD: begin
                // A count of 0 or 1 both mean this is the last dead clock.
                if (dead_cnt_reg <= MXDRB'(1)) begin
                    dead_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    dead_cnt_next = dead_cnt_reg - MXDRB'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            state_reg     <= ST_IDLE;
            dead_cnt_reg  <= '0;
            done_reg      <= 1'b0;
            clct0_key_reg <= '0;
            clct1_key_reg <= '0;
            clct0_vld_reg <= 1'b0;
            clct1_vld_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dead_cnt_reg <= dead_cnt_next;
            done_reg     <= done_next;
            if (latch0) begin
                clct0_key_reg <= best_key;
                clct0_vld_reg <= 1'b1;
                clct1_key_reg <= '0;
                clct1_vld_reg <= 1'b0;
            end else if (latch1) begin
                clct1_key_reg <= best_key;
                clct1_vld_reg <= 1'b1;
            end
        end
    end

    wire unused_busy = ^busy_vec;

    assign clct0_key   = clct0_key_reg;
    assign clct1_key   = clct1_key_reg;
    assign clct0_vld   = clct0_vld_reg;
    assign clct1_vld   = clct1_vld_reg;
    assign clct_done   = done_reg;
    assign sched_state = state_reg;

endmodule
